// File: rtl/lb_clock_counter_pkg.sv
// lb_clock_counter_pkg: shared UART timing constants (counter width, clock rate, baud divisors)
package lb_clock_counter_pkg;
  localparam int CLK_COUNT_WIDTH = 20;
  localparam int CLK_FREQ_HZ     = 50_000_000;
  localparam logic [CLK_COUNT_WIDTH-1:0] BAUD_DIV_9600   = CLK_COUNT_WIDTH'(CLK_FREQ_HZ / 9600);
  localparam logic [CLK_COUNT_WIDTH-1:0] BAUD_DIV_19200  = CLK_COUNT_WIDTH'(CLK_FREQ_HZ / 19200);
  localparam logic [CLK_COUNT_WIDTH-1:0] BAUD_DIV_57600  = CLK_COUNT_WIDTH'(CLK_FREQ_HZ / 57600);
  localparam logic [CLK_COUNT_WIDTH-1:0] BAUD_DIV_115200 = CLK_COUNT_WIDTH'(CLK_FREQ_HZ / 115200);
  function automatic logic [CLK_COUNT_WIDTH-1:0] baud_divisor(input int baud);
    return CLK_COUNT_WIDTH'(CLK_FREQ_HZ / baud);
  endfunction
endpackage

// File: rtl/lb_clock_counter.sv
// lb_clock_counter: free-running divider strobing done every value cycles; ports clk, reset (sync active-low), value (divisor), done (registered strobe)
module lb_clock_counter
  import lb_clock_counter_pkg::*;
#(
  parameter int WIDTH = CLK_COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  output logic             done
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             w_terminal;
  // value <= 1 short-circuits before value - 1 could wrap; >= lets a lowered divisor end the period at once
  assign w_terminal = (value <= ONE) || (r_count >= value - ONE);
  assign done       = r_done;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_terminal ? '0 : r_count + ONE;
      r_done  <= w_terminal;
    end
  end
`ifndef SYNTHESIS
  a_no_double_done: assert property (@(posedge clk) disable iff (!reset) (done && value >= WIDTH'(2)) |=> !done);
`endif
endmodule

// File: tb/tb_lb_clock_counter.sv
// tb_lb_clock_counter: directed vector table plus multi-cycle sequences for lb_clock_counter
module tb_lb_clock_counter;
  typedef struct {
    logic        rst;
    logic [19:0] val;
    logic        exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] value = 20'd2;
  logic        done;
  logic        reset2 = 1'b0;
  logic [7:0]  value2 = 8'd255;
  logic        done2;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vecs[$];
  lb_clock_counter dut (.clk(clk), .reset(reset), .value(value), .done(done));
  lb_clock_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset2), .value(value2), .done(done2));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [19:0] v, input logic e);
    vec_t x;
    x.rst = r;
    x.val = v;
    x.exp = e;
    vecs.push_back(x);
  endtask
  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < max);
    if (!done) n = -1;
  endtask
  task automatic restart(input logic [19:0] v);
    reset = 1'b0;
    value = v;
    tick();
    reset = 1'b1;
  endtask
  initial begin
    int n, cnt, first, second, dbl, hi;
    logic prev;
    for (int i = 0; i < 3; i++) add(1'b0, 20'd2, 1'b0);
    add(1'b1, 20'd2, 1'b0); add(1'b1, 20'd2, 1'b1); add(1'b1, 20'd2, 1'b0); add(1'b1, 20'd2, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b1, 20'd1, 1'b1);
    add(1'b1, 20'd0, 1'b1); add(1'b1, 20'd0, 1'b1);
    add(1'b0, 20'd0, 1'b0); add(1'b1, 20'd0, 1'b1);
    add(1'b1, 20'd3, 1'b0); add(1'b1, 20'd3, 1'b0); add(1'b1, 20'd3, 1'b1); add(1'b1, 20'd3, 1'b0);
    add(1'b0, 20'd3, 1'b0); add(1'b1, 20'd3, 1'b0); add(1'b1, 20'd3, 1'b0); add(1'b1, 20'd3, 1'b1);
    #1;
    chk("reset_state", int'(done), 0);
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      value = vecs[i].val;
      tick();
      chk($sformatf("vec%0d", i), int'(done), int'(vecs[i].exp));
    end
    reset = 1'b0;
    value = 20'd200;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      hi += int'(done);
    end
    chk("hold_reset_low", hi, 0);
    reset = 1'b1;
    cnt = 0; first = -1; second = -1; dbl = 0; prev = 1'b0;
    for (int e = 1; e <= 1000; e++) begin
      tick();
      if (done) begin
        cnt++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      if (done && prev) dbl++;
      prev = done;
    end
    chk("first_strobe_edge", first, 200);
    chk("second_strobe_edge", second, 400);
    chk("strobes_in_1000", cnt, 5);
    chk("no_double_strobe", dbl, 0);
    restart(20'd200);
    for (int i = 0; i < 150; i++) tick();
    chk("pre_midreset_done", int'(done), 0);
    reset = 1'b0;
    tick();
    chk("midreset_done", int'(done), 0);
    reset = 1'b1;
    wait_done(400, n);
    chk("after_midreset_period", n, 200);
    tick();
    chk("strobe_one_cycle", int'(done), 0);
    restart(20'd200);
    for (int i = 0; i < 100; i++) tick();
    value = 20'd50;
    tick();
    chk("lowered_value_immediate", int'(done), 1);
    wait_done(400, n);
    chk("lowered_value_period", n, 50);
    for (int i = 0; i < 10; i++) tick();
    value = 20'd200;
    wait_done(400, n);
    chk("raised_value_remaining", n, 190);
    restart(20'd4);
    tick();
    tick();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    wait_done(20, n);
    chk("unsampled_reset_glitch", n, 2);
    reset2 = 1'b1;
    n = -1; hi = 0; first = -1;
    for (int e = 1; e <= 520; e++) begin
      tick();
      if (done2) begin
        if (n < 0) n = e;
        else if (first < 0) first = e;
        hi++;
      end
    end
    chk("max_div_first", n, 255);
    chk("max_div_second", first, 510);
    chk("max_div_count", hi, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
